// File: rtl/sram_sp_be_reg_based_with_flag_bank_ring_pkg.sv
// Shared definitions for the flagged byte-enable bank ring.
//   FUNC_LOG2(x)  : address/index width for x items (minimum 1 bit)
//   KnobRegout*   : encodings for the KNOB_REGOUT read-latency parameter
//   ring_inc()    : ring pointer increment with explicit wrap at num-1
// Optional feature macro used by the ring: SRAM_RING_OCC_CNT_EN.

`ifndef FUNC_LOG2
`define FUNC_LOG2(x) (((x) <= 1) ? 1 : $clog2(x))
`endif

package sram_sp_be_reg_based_with_flag_bank_ring_pkg;

  // Unset sentinel; every instantiation must choose 1-cycle or 2-cycle read.
  localparam int KnobRegoutUnset = -1;
  localparam int KnobRegout1Cyc  = 0;
  localparam int KnobRegout2Cyc  = 1;

  // Explicit compare so non-power-of-two bank counts wrap correctly.
  function automatic int unsigned ring_inc(input int unsigned ptr, input int unsigned num);
    return (ptr == num - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/sram_sp_be_reg_based_flag_bank.sv
// One bank of the ring: register array with per-column byte enables and a
// per-column "written" flag for every entry.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset (flags only)
//   wr_val_i       per-column write enable (already gated to this bank)
//   wr_adr_i/dat_i write address / data
//   clr_i          clear every flag of this bank at the next edge
//   rd_adr_i       read address (combinational read)
//   rd_dat_o       read data, columns with a clear flag forced to 0
//   rd_flg_o       flags of the addressed entry
//   occ_cnt_o      entries with any flag set (only with SRAM_RING_OCC_CNT_EN)

module sram_sp_be_reg_based_flag_bank
  import sram_sp_be_reg_based_with_flag_bank_ring_pkg::*;
#(
  parameter int unsigned SIZE     = 64,
  parameter int unsigned SIZE_COL = 8,
  parameter int unsigned DATA_WD  = 32,
  parameter int unsigned SIZE_WD  = 6,
  parameter int unsigned COL_NUM  = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [COL_NUM-1:0] wr_val_i,
  input  logic [SIZE_WD-1:0] wr_adr_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  input  logic               clr_i,
  input  logic [SIZE_WD-1:0] rd_adr_i,
  output logic [DATA_WD-1:0] rd_dat_o,
  output logic [COL_NUM-1:0] rd_flg_o
`ifdef SRAM_RING_OCC_CNT_EN
  ,
  output logic [SIZE_WD:0]   occ_cnt_o
`endif
);

  logic [DATA_WD-1:0] mem_q [SIZE];
  logic [COL_NUM-1:0] flg_q [SIZE];
  logic [COL_NUM-1:0] flg_rd;

  // Array contents are intentionally not reset; flags decide visibility.
  always_ff @(posedge clk) begin
    for (int unsigned c = 0; c < COL_NUM; c++) begin
      if (wr_val_i[c]) begin
        mem_q[wr_adr_i][c*SIZE_COL +: SIZE_COL] <= wr_dat_i[c*SIZE_COL +: SIZE_COL];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < SIZE; i++) flg_q[i] <= '0;
    end else if (clr_i) begin
      for (int unsigned i = 0; i < SIZE; i++) flg_q[i] <= '0;
    end else if (|wr_val_i) begin
      flg_q[wr_adr_i] <= flg_q[wr_adr_i] | wr_val_i;
    end
  end

  always_comb begin
    flg_rd   = flg_q[rd_adr_i];
    rd_dat_o = '0;
    for (int unsigned c = 0; c < COL_NUM; c++) begin
      if (flg_rd[c]) rd_dat_o[c*SIZE_COL +: SIZE_COL] = mem_q[rd_adr_i][c*SIZE_COL +: SIZE_COL];
    end
  end

  assign rd_flg_o = flg_rd;

`ifdef SRAM_RING_OCC_CNT_EN
  logic [SIZE_WD:0] occ_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      occ_q <= '0;
    end else if (clr_i) begin
      occ_q <= '0;
    end else if ((|wr_val_i) && (flg_q[wr_adr_i] == '0)) begin
      // First write to a still-empty entry.
      occ_q <= occ_q + (SIZE_WD+1)'(1);
    end
  end

  assign occ_cnt_o = occ_q;
`endif

endmodule

// File: rtl/sram_sp_be_reg_based_with_flag_bank_ring.sv
// Byte-enable register SRAM split into NUMB_BNK flagged banks, run as a
// producer/consumer ring. The writer fills and commits the bank at the write
// pointer; the reader drains and releases the bank at the read pointer, and
// release wipes that bank's flags so it comes back empty.
// Ports:
//   clk, rstn                  clock, asynchronous active-low reset
//   wr_val_i/adr_i/dat_i       per-column write into the write bank
//   wr_done_i                  commit the write bank
//   wr_rdy_o, wr_idx_bnk_o     free bank available / current write bank
//   rd_val_i/adr_i             read request from the read bank
//   rd_done_i                  release the read bank
//   rd_rdy_o, rd_idx_bnk_o     committed bank available / current read bank
//   rd_val_o/dat_o/flg_o       read return (1 or 2 cycles, see KNOB_REGOUT)
//   cnt_ful_o                  number of committed banks
//   occ_cnt_o                  read bank occupancy (only with SRAM_RING_OCC_CNT_EN)

module sram_sp_be_reg_based_with_flag_bank_ring
  import sram_sp_be_reg_based_with_flag_bank_ring_pkg::*;
#(
  parameter  int          KNOB_REGOUT = KnobRegoutUnset,
  parameter  int unsigned NUMB_BNK    = 2,
  parameter  int unsigned SIZE        = 64,
  parameter  int unsigned SIZE_COL    = 8,
  parameter  int unsigned DATA_WD     = 32,
  localparam int unsigned SIZE_WD     = `FUNC_LOG2(SIZE),
  localparam int unsigned BNK_WD      = `FUNC_LOG2(NUMB_BNK),
  localparam int unsigned COL_NUM     = DATA_WD / SIZE_COL
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [COL_NUM-1:0] wr_val_i,
  input  logic [SIZE_WD-1:0] wr_adr_i,
  input  logic [DATA_WD-1:0] wr_dat_i,
  input  logic               wr_done_i,
  output logic               wr_rdy_o,
  output logic [BNK_WD-1:0]  wr_idx_bnk_o,
  input  logic               rd_val_i,
  input  logic [SIZE_WD-1:0] rd_adr_i,
  input  logic               rd_done_i,
  output logic               rd_rdy_o,
  output logic [BNK_WD-1:0]  rd_idx_bnk_o,
  output logic               rd_val_o,
  output logic [DATA_WD-1:0] rd_dat_o,
  output logic [COL_NUM-1:0] rd_flg_o,
  output logic [BNK_WD:0]    cnt_ful_o
`ifdef SRAM_RING_OCC_CNT_EN
  ,
  output logic [SIZE_WD:0]   occ_cnt_o
`endif
);

  logic [BNK_WD-1:0] wr_ptr_q, wr_ptr_d;
  logic [BNK_WD-1:0] rd_ptr_q, rd_ptr_d;
  logic [BNK_WD:0]   cnt_q, cnt_d;

  logic wr_rdy, rd_rdy, wr_commit, rd_release, rd_fire;

  assign wr_rdy     = cnt_q < (BNK_WD+1)'(NUMB_BNK);
  assign rd_rdy     = cnt_q != '0;
  assign wr_commit  = wr_done_i && wr_rdy;
  assign rd_release = rd_done_i && rd_rdy;
  assign rd_fire    = rd_val_i && rd_rdy;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_commit)  wr_ptr_d = BNK_WD'(ring_inc(32'(wr_ptr_q), NUMB_BNK));
    if (rd_release) rd_ptr_d = BNK_WD'(ring_inc(32'(rd_ptr_q), NUMB_BNK));
    case ({wr_commit, rd_release})
      2'b10:   cnt_d = cnt_q + (BNK_WD+1)'(1);
      2'b01:   cnt_d = cnt_q - (BNK_WD+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign wr_rdy_o     = wr_rdy;
  assign rd_rdy_o     = rd_rdy;
  assign wr_idx_bnk_o = wr_ptr_q;
  assign rd_idx_bnk_o = rd_ptr_q;
  assign cnt_ful_o    = cnt_q;

  logic [COL_NUM-1:0] bnk_wr_val [NUMB_BNK];
  logic               bnk_clr    [NUMB_BNK];
  logic [DATA_WD-1:0] bnk_dat    [NUMB_BNK];
  logic [COL_NUM-1:0] bnk_flg    [NUMB_BNK];
`ifdef SRAM_RING_OCC_CNT_EN
  logic [SIZE_WD:0]   bnk_occ    [NUMB_BNK];
`endif

  for (genvar b = 0; b < NUMB_BNK; b++) begin : g_bnk
    // The write bank is never committed and the read bank always is, so a
    // bank never sees a write and a clear in the same cycle.
    assign bnk_wr_val[b] = (wr_rdy && (wr_ptr_q == BNK_WD'(b))) ? wr_val_i : '0;
    assign bnk_clr[b]    = rd_release && (rd_ptr_q == BNK_WD'(b));

    sram_sp_be_reg_based_flag_bank #(
      .SIZE     (SIZE),
      .SIZE_COL (SIZE_COL),
      .DATA_WD  (DATA_WD),
      .SIZE_WD  (SIZE_WD),
      .COL_NUM  (COL_NUM)
    ) u_bank (
      .clk      (clk),
      .rstn     (rstn),
      .wr_val_i (bnk_wr_val[b]),
      .wr_adr_i (wr_adr_i),
      .wr_dat_i (wr_dat_i),
      .clr_i    (bnk_clr[b]),
      .rd_adr_i (rd_adr_i),
      .rd_dat_o (bnk_dat[b]),
      .rd_flg_o (bnk_flg[b])
`ifdef SRAM_RING_OCC_CNT_EN
      ,
      .occ_cnt_o(bnk_occ[b])
`endif
    );
  end

`ifdef SRAM_RING_OCC_CNT_EN
  assign occ_cnt_o = bnk_occ[rd_ptr_q];
`endif

  // First read stage captures at the request edge, i.e. before a same-cycle
  // release clears the flags.
  logic               rd_val_s1_q;
  logic [DATA_WD-1:0] rd_dat_s1_q;
  logic [COL_NUM-1:0] rd_flg_s1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_val_s1_q <= 1'b0;
      rd_dat_s1_q <= '0;
      rd_flg_s1_q <= '0;
    end else begin
      rd_val_s1_q <= rd_fire;
      if (rd_fire) begin
        rd_dat_s1_q <= bnk_dat[rd_ptr_q];
        rd_flg_s1_q <= bnk_flg[rd_ptr_q];
      end
    end
  end

  if (KNOB_REGOUT == KnobRegout1Cyc) begin : g_rd_1cyc
    assign rd_val_o = rd_val_s1_q;
    assign rd_dat_o = rd_dat_s1_q;
    assign rd_flg_o = rd_flg_s1_q;
  end else begin : g_rd_2cyc
    logic               rd_val_s2_q;
    logic [DATA_WD-1:0] rd_dat_s2_q;
    logic [COL_NUM-1:0] rd_flg_s2_q;

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        rd_val_s2_q <= 1'b0;
        rd_dat_s2_q <= '0;
        rd_flg_s2_q <= '0;
      end else begin
        rd_val_s2_q <= rd_val_s1_q;
        if (rd_val_s1_q) begin
          rd_dat_s2_q <= rd_dat_s1_q;
          rd_flg_s2_q <= rd_flg_s1_q;
        end
      end
    end

    assign rd_val_o = rd_val_s2_q;
    assign rd_dat_o = rd_dat_s2_q;
    assign rd_flg_o = rd_flg_s2_q;
  end

endmodule

// File: doc/sram_sp_be_reg_based_with_flag_bank_ring.md
Name: sram_sp_be_reg_based_with_flag_bank_ring

Overview:
Register-based byte-enable SRAM split into NUMB_BNK banks with a per-column "written" flag, managed as a producer/consumer bank ring.
- The writer fills the bank at the write pointer and commits it; the reader drains the bank at the read pointer and releases it. Release clears that bank's flags.
- Bank count is a parameter, not a global define. Bank selection is internal, not driven by the caller.
- Sits between a stage that writes blocks and the next stage that reads them, replacing externally-indexed multi-bank buffers.

Parameters:
- KNOB_REGOUT, -1, read output register: 0 = 1-cycle read, 1 = 2-cycle read. -1 is illegal.
- NUMB_BNK, 2, number of banks. Any value ≥ 2; need not be a power of two.
- SIZE, 64, entries per bank.
- SIZE_COL, 8, bits per byte-enable column. DATA_WD must be a multiple of SIZE_COL.
- DATA_WD, 32, data width.
- Derived, local: SIZE_WD = log2(SIZE); BNK_WD = log2(NUMB_BNK); COL_NUM = DATA_WD/SIZE_COL.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- wr_val_i  in  COL_NUM  per-column write enable
- wr_adr_i  in  SIZE_WD  write address
- wr_dat_i  in  DATA_WD  write data
- wr_done_i  in  1  commit current write bank
- wr_rdy_o  out  1  a free bank is available for writing
- wr_idx_bnk_o  out  BNK_WD  current write bank
- rd_val_i  in  1  read request
- rd_adr_i  in  SIZE_WD  read address
- rd_done_i  in  1  release current read bank
- rd_rdy_o  out  1  a committed bank is available for reading
- rd_idx_bnk_o  out  BNK_WD  current read bank
- rd_val_o  out  1  read data valid
- rd_dat_o  out  DATA_WD  read data; columns whose flag is clear read as 0
- rd_flg_o  out  COL_NUM  per-column written flags of the returned entry
- cnt_ful_o  out  BNK_WD+1  number of committed banks

Behaviour:
- Reset (async):
  - wr_ptr = rd_ptr = cnt = 0.
  - All flags = 0.
  - rd_val_o, rd_dat_o, rd_flg_o = 0.
  - Any in-flight read is dropped; no rd_val_o after reset.
  - Array data is not reset.
- Status outputs:
  - wr_rdy_o = (cnt < NUMB_BNK).
  - rd_rdy_o = (cnt > 0).
  - wr_idx_bnk_o = wr_ptr; rd_idx_bnk_o = rd_ptr.
- Write:
  - Effective only when wr_rdy_o is high.
  - Column c of entry wr_adr_i in bank wr_ptr is written, and its flag set, when wr_val_i[c] is high.
  - wr_val_i is ignored when wr_rdy_o is low.
- Commit (wr_done_i && wr_rdy_o):
  - wr_ptr advances; wraps from NUMB_BNK-1 to 0 by explicit compare.
  - cnt increments.
  - Writes in the same cycle land in the old bank.
  - Committing a bank with no writes is legal; it reads as all zeros.
- Read:
  - Effective only when rd_rdy_o is high; rd_val_i is ignored otherwise and produces no rd_val_o.
  - Bank and address are captured at request.
  - KNOB_REGOUT=0: rd_val_o, rd_dat_o and rd_flg_o are valid one cycle later.
  - KNOB_REGOUT=1: valid two cycles later; data register holds its value when no read.
- Release (rd_done_i && rd_rdy_o):
  - All flags of bank rd_ptr are cleared at the next edge.
  - rd_ptr advances with wrap; cnt decrements.
  - A read issued in the same cycle returns pre-clear data and flags.
- Simultaneous commit and release: cnt unchanged, both pointers advance.
- Writer and reader cannot target the same bank: the write bank is never committed, the read bank always is.
- wr_done_i when wr_rdy_o is low, and rd_done_i when rd_rdy_o is low, are ignored.

Optional Feature:
SRAM_RING_OCC_CNT_EN
- Defined:
  - Each bank keeps a count (SIZE_WD+1 bits) of entries with any flag set.
  - The count increments on the first write to an entry and clears on release.
  - Extra output occ_cnt_o (SIZE_WD+1) gives the read bank's count.
- Undefined: no counters and no occ_cnt_o port.

Decomposition:
- Shared package/header: FUNC_LOG2 macro, KNOB_REGOUT encodings, ring pointer-increment function.
- Natural sub-module: sram_sp_be_reg_based_flag_bank, one bank holding array and flags, with a flag-clear input. Instantiate it NUMB_BNK times in a generate loop.
- The top level holds pointers, count and the output pipeline.

Test Plan:
- After reset, NUMB_BNK=2 → cnt_ful_o=0, wr_rdy_o=1, rd_rdy_o=0; rd_val_i pulse → no rd_val_o.
- Write adr 5 = 0xA5A5A5A5 with wr_val_i=4'b0101, commit, read adr 5 → rd_dat_o=0x00A500A5, rd_flg_o=4'b0101, latency 1 (KNOB_REGOUT=0) or 2 (KNOB_REGOUT=1).
- Commit 2 banks → wr_rdy_o=0, cnt_ful_o=2. Further writes are ignored: after release, the bank read back has no stray data.
- NUMB_BNK=3: commit/release 7 times → pointers wrap 0,1,2,0,…; wr_idx_bnk_o never equals 3.
- rd_val_i and rd_done_i in the same cycle → old data returned; after wraparound the same bank reads as 0 until rewritten.
- Commit and release in the same cycle with cnt=1 → cnt stays 1; assert rstn mid-read → rd_val_o stays 0.
